// File: rtl/dso100fb_video_capture.sv
// Receive side of the parallel video port: samples RGB video, aligns it to
// frame start and pushes active pixels into the pixel FIFO with SOF/EOL tags.
module dso100fb_video_capture #(
    parameter int DATA_WIDTH = 32,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  VIDCLK,
    input  logic                  RST,
    input  logic                  CAPTURE_EN,
    input  logic                  ERR_CLR,
    input  logic [DATA_WIDTH-1:0] VID_DATA,
    input  logic                  VID_DE,
    input  logic                  VID_HSYNC,
    input  logic                  VID_VSYNC,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WRITE,
    output logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  FIFO_SOF,
    output logic                  FIFO_EOL,
    output logic                  FRAME_DONE,
    output logic                  OVERFLOW,
    output logic                  GEOM_ERR,
    output logic [CNT_WIDTH-1:0]  LINE_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACTIVE,
        DROP
    } state_t;

    localparam logic [CNT_WIDTH:0]   H_EXP   = (CNT_WIDTH+1)'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_EXP   = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
    logic                  s1_de_q, s2_de_q;
    logic                  s1_vs_q, s2_vs_q;

    logic [CNT_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic [CNT_WIDTH-1:0]  x_sat, y_sat;
    logic [CNT_WIDTH:0]    x_len;

    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sof_q, sof_d;
    logic                  eol_q, eol_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  geom_q, geom_d;
    logic                  ovf_set, geom_set;

    logic                  fs, eol;
    logic                  unused_hsync;

    // HSYNC carries timing only; the capture path frames on DE and VSYNC.
    assign unused_hsync = VID_HSYNC ^ HSYNC_POL;

    assign fs    = s1_vs_q & ~s2_vs_q;
    assign eol   = s2_de_q & ~s1_de_q;
    assign x_len = {1'b0, x_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign x_sat = (&x_q) ? x_q : x_len[CNT_WIDTH-1:0];
    assign y_sat = (&y_q) ? y_q : y_q + CNT_ONE;

    always_ff @(posedge VIDCLK or posedge RST) begin
        if (RST) begin
            s1_data_q <= '0;
            s2_data_q <= '0;
            s1_de_q   <= 1'b0;
            s2_de_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            geom_q    <= 1'b0;
        end else begin
            s1_data_q <= VID_DATA;
            s2_data_q <= s1_data_q;
            s1_de_q   <= VID_DE;
            s2_de_q   <= s1_de_q;
            s1_vs_q   <= (VID_VSYNC == VSYNC_POL);
            s2_vs_q   <= s1_vs_q;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            geom_q    <= geom_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        wr_d     = 1'b0;
        data_d   = data_q;
        sof_d    = 1'b0;
        eol_d    = 1'b0;
        done_d   = 1'b0;
        ovf_set  = 1'b0;
        geom_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (CAPTURE_EN) state_d = WAIT;
            end
            WAIT: begin
                if (fs) state_d = CAPTURE_EN ? ACTIVE : IDLE;
            end
            ACTIVE: begin
                if (fs) begin
                    done_d   = 1'b1;
                    geom_set = (y_q != V_EXP);
                    state_d  = CAPTURE_EN ? ACTIVE : IDLE;
                end else if (s2_de_q) begin
                    if (FIFO_FULL) begin
                        ovf_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = s2_data_q;
                        sof_d  = (x_q == '0) && (y_q == '0);
                        eol_d  = eol;
                        if (y_q >= V_EXP) geom_set = 1'b1;
                        if (eol) begin
                            if (x_len != H_EXP) geom_set = 1'b1;
                            x_d = '0;
                            y_d = y_sat;
                        end else begin
                            x_d = x_sat;
                        end
                    end
                end
            end
            DROP: begin
                if (fs) state_d = CAPTURE_EN ? ACTIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every frame start restarts geometry tracking.
        if (fs) begin
            x_d = '0;
            y_d = '0;
        end

        // A new error in the same cycle as ERR_CLR keeps the flag set.
        ovf_d  = (ovf_q & ~ERR_CLR) | ovf_set;
        geom_d = (geom_q & ~ERR_CLR) | geom_set;
    end

    assign FIFO_WRITE = wr_q;
    assign FIFO_DATA  = data_q;
    assign FIFO_SOF   = sof_q;
    assign FIFO_EOL   = eol_q;
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;
    assign GEOM_ERR   = geom_q;
    assign LINE_COUNT = y_q;

endmodule

// File: tb/tb_dso100fb_video_capture.sv
// Bench for dso100fb_video_capture: directed frame scenarios plus random
// frames, both VSYNC polarities, checked against a frame-level model.
module tb_dso100fb_video_capture;

    localparam int DW = 32;
    localparam int CW = 12;
    localparam int H  = 4;
    localparam int V  = 3;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_CAP  = 2;
    localparam int M_DROP = 3;

    logic          clk = 1'b0;
    logic          rst, en, clr, de, vs, full;
    logic          vs_n;
    logic [DW-1:0] data;

    logic          p_wr, p_sof, p_eol, p_done, p_ovf, p_geom;
    logic [DW-1:0] p_data;
    logic [CW-1:0] p_lc;
    logic          n_wr, n_sof, n_eol, n_done, n_ovf, n_geom;
    logic [DW-1:0] n_data;
    logic [CW-1:0] n_lc;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;
    int w0, s0, e0, d0;
    int px_idx = 0;
    bit rnd_on = 0;
    bit clr_req = 0;
    bit [1:0] fq = 2'b00;

    int            mode;
    int            lines;
    int            frame_px;
    logic [DW-1:0] line_q[$];
    bit            h1_vs, h2_vs, h1_de, h2_de;
    logic [DW-1:0] h1_d, h2_d;
    bit            e_wr, e_sof, e_eol, e_done, e_ovf, e_geom;
    logic [DW-1:0] e_data;
    int            e_lc;

    assign vs_n = ~vs;

    always #5 clk = ~clk;

    dso100fb_video_capture #(
        .DATA_WIDTH(DW), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(CW)
    ) dut_p (
        .VIDCLK(clk), .RST(rst), .CAPTURE_EN(en), .ERR_CLR(clr),
        .VID_DATA(data), .VID_DE(de), .VID_HSYNC(1'b0), .VID_VSYNC(vs),
        .FIFO_FULL(full), .FIFO_WRITE(p_wr), .FIFO_DATA(p_data),
        .FIFO_SOF(p_sof), .FIFO_EOL(p_eol), .FRAME_DONE(p_done),
        .OVERFLOW(p_ovf), .GEOM_ERR(p_geom), .LINE_COUNT(p_lc)
    );

    dso100fb_video_capture #(
        .DATA_WIDTH(DW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(CW)
    ) dut_n (
        .VIDCLK(clk), .RST(rst), .CAPTURE_EN(en), .ERR_CLR(clr),
        .VID_DATA(data), .VID_DE(de), .VID_HSYNC(1'b1), .VID_VSYNC(vs_n),
        .FIFO_FULL(full), .FIFO_WRITE(n_wr), .FIFO_DATA(n_data),
        .FIFO_SOF(n_sof), .FIFO_EOL(n_eol), .FRAME_DONE(n_done),
        .OVERFLOW(n_ovf), .GEOM_ERR(n_geom), .LINE_COUNT(n_lc)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        lines = 0;
        frame_px = 0;
        line_q.delete();
        h1_vs = 0; h2_vs = 0; h1_de = 0; h2_de = 0;
        h1_d = '0; h2_d = '0;
        e_wr = 0; e_sof = 0; e_eol = 0; e_done = 0;
        e_ovf = 0; e_geom = 0; e_data = '0; e_lc = 0;
    endtask

    // One clock of the reference: the pixel two inputs back is the one being
    // judged, the pixel one input back tells whether its DE run ends here.
    task automatic model_step();
        bit fs, eol, err, ov;
        fs  = h1_vs && !h2_vs;
        eol = h2_de && !h1_de;
        err = 0;
        ov  = 0;
        e_wr = 0; e_sof = 0; e_eol = 0; e_done = 0;
        case (mode)
            M_IDLE: if (en) mode = M_WAIT;
            M_WAIT: if (fs) mode = en ? M_CAP : M_IDLE;
            M_CAP: begin
                if (fs) begin
                    e_done = 1;
                    err = (lines != V);
                    mode = en ? M_CAP : M_IDLE;
                end else if (h2_de) begin
                    if (full) begin
                        ov = 1;
                        mode = M_DROP;
                    end else begin
                        e_wr = 1;
                        e_data = h2_d;
                        e_sof = (frame_px == 0);
                        e_eol = eol;
                        frame_px++;
                        line_q.push_back(h2_d);
                        if (lines >= V) err = 1;
                        if (eol) begin
                            if (line_q.size() != H) err = 1;
                            line_q.delete();
                            if (lines < 4095) lines++;
                        end
                    end
                end
            end
            M_DROP: if (fs) mode = en ? M_CAP : M_IDLE;
            default: mode = M_IDLE;
        endcase
        if (fs) begin
            lines = 0;
            frame_px = 0;
            line_q.delete();
        end
        e_ovf  = (e_ovf && !clr) || ov;
        e_geom = (e_geom && !clr) || err;
        e_lc   = lines;
        h2_vs = h1_vs; h2_de = h1_de; h2_d = h1_d;
        h1_vs = vs;    h1_de = de;    h1_d = data;
    endtask

    task automatic check_all();
        chk("wr", p_wr, e_wr);
        chk("wr_n", n_wr, e_wr);
        if (e_wr) begin
            chk("data", p_data, e_data);
            chk("data_n", n_data, e_data);
            chk("sof", p_sof, e_sof);
            chk("sof_n", n_sof, e_sof);
            chk("eol", p_eol, e_eol);
            chk("eol_n", n_eol, e_eol);
        end
        chk("done", p_done, e_done);
        chk("done_n", n_done, e_done);
        chk("ovf", p_ovf, e_ovf);
        chk("ovf_n", n_ovf, e_ovf);
        chk("geom", p_geom, e_geom);
        chk("geom_n", n_geom, e_geom);
        chk("lc", p_lc, e_lc);
        chk("lc_n", n_lc, e_lc);
        if (p_wr) wr_cnt++;
        if (p_wr && p_sof) sof_cnt++;
        if (p_wr && p_eol) eol_cnt++;
        if (p_done) done_cnt++;
    endtask

    // f marks FIFO_FULL for the moment this pixel reaches the second stage.
    task automatic cyc(input bit v, input bit d, input logic [DW-1:0] dat,
                       input bit f);
        vs = v;
        de = d;
        data = dat;
        full = fq[1];
        fq[1] = fq[0];
        fq[0] = f;
        clr = clr_req || (rnd_on && $urandom_range(0, 39) == 0);
        clr_req = 0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0);
    endtask

    task automatic vhdr();
        px_idx = 0;
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        blank(2);
    endtask

    task automatic line(input int n, input int full_px);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, $urandom,
                (px_idx == full_px) || (rnd_on && $urandom_range(0, 29) == 0));
            px_idx++;
        end
        blank(3);
    endtask

    task automatic frame(input int nl, input int short_ln, input int full_px,
                         input int en_off, input int en_on);
        vhdr();
        for (int l = 0; l < nl; l++) begin
            if (l == en_off) en = 0;
            if (l == en_on) en = 1;
            line((l == short_ln) ? H - 1 : H, full_px);
        end
    endtask

    task automatic snap();
        w0 = wr_cnt;
        s0 = sof_cnt;
        e0 = eol_cnt;
        d0 = done_cnt;
    endtask

    task automatic pulse_clr();
        clr_req = 1;
        blank(2);
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; de = 0; vs = 0; full = 0; data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 0;
        blank(2);

        en = 1;
        blank(3);
        snap();
        frame(V, -1, -1, -1, -1);
        chk("t1_writes", wr_cnt - w0, 12);
        chk("t1_sof", sof_cnt - s0, 1);
        chk("t1_eol", eol_cnt - e0, 3);
        chk("t1_geom", p_geom, 0);

        snap();
        frame(V, -1, 5, -1, -1);
        chk("t2_writes", wr_cnt - w0, 5);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_ovf", p_ovf, 1);

        snap();
        frame(V, -1, -1, -1, -1);
        chk("t3_writes", wr_cnt - w0, 12);
        chk("t3_done", done_cnt - d0, 0);
        chk("t3_ovf", p_ovf, 1);
        pulse_clr();
        chk("t3_ovf_clr", p_ovf, 0);

        snap();
        frame(V, 1, -1, -1, -1);
        chk("t4_writes", wr_cnt - w0, 11);
        chk("t4_geom", p_geom, 1);
        pulse_clr();
        chk("t4_geom_clr", p_geom, 0);

        snap();
        frame(V + 1, -1, -1, -1, -1);
        chk("t5_writes", wr_cnt - w0, 16);
        chk("t5_lc", p_lc, 4);
        pulse_clr();
        chk("t5_geom_clr", p_geom, 0);

        snap();
        frame(V, -1, -1, 1, -1);
        chk("t6_writes", wr_cnt - w0, 12);
        chk("t6_geom_fs", p_geom, 1);
        snap();
        frame(V, -1, -1, -1, -1);
        chk("t7_writes", wr_cnt - w0, 0);
        chk("t7_done", done_cnt - d0, 1);
        pulse_clr();

        snap();
        frame(V, -1, -1, -1, 1);
        chk("t8_writes", wr_cnt - w0, 0);
        snap();
        frame(V, -1, -1, -1, -1);
        chk("t8b_writes", wr_cnt - w0, 12);
        chk("t8b_sof", sof_cnt - s0, 1);

        vhdr();
        line(H - 1, -1);
        cyc(0, 1, $urandom, 0);
        cyc(0, 1, $urandom, 0);
        chk("t9_geom_pre", p_geom, 1);
        vs = 0; de = 1; data = $urandom;
        #2 rst = 1;
        #1;
        chk("rst_wr", p_wr, 0);
        chk("rst_data", p_data, 0);
        chk("rst_geom", p_geom, 0);
        chk("rst_lc", p_lc, 0);
        chk("rst_ovf", p_ovf, 0);
        chk("rst_geom_n", n_geom, 0);
        chk("rst_lc_n", n_lc, 0);
        model_reset();
        fq = 2'b00;
        full = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        snap();
        cyc(0, 1, $urandom, 0);
        cyc(0, 1, $urandom, 0);
        blank(3);
        line(H, -1);
        chk("t9_writes_after_rst", wr_cnt - w0, 0);
        snap();
        frame(V, -1, -1, -1, -1);
        chk("t9_writes_frame", wr_cnt - w0, 12);

        rnd_on = 1;
        for (int f = 0; f < 16; f++) begin
            int nl, sl, off;
            en = ($urandom_range(0, 4) != 0);
            nl = $urandom_range(2, 4);
            sl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
            off = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nl - 1) : -1;
            frame(nl, sl, -1, off, -1);
        end
        rnd_on = 0;
        en = 1;
        frame(V, -1, -1, -1, -1);
        blank(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
